pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, branch/jump
// flush, SYSCALL drain-and-halt sequencing, plus saturating stall/flush counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_syscall,
  input  logic        id_jmp,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        go,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_dcnt, w_dcnt_nxt;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_lu, w_stall_ev, w_flush_ev;
  logic        w_mem_a, w_wb_a, w_mem_b, w_wb_b;
  logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_halted;

  // Forwarding is purely combinational; the younger MEM result wins over WB.
  assign w_mem_a = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs);
  assign w_wb_a  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs);
  assign w_mem_b = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rt);
  assign w_wb_b  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == ex_rt);
  assign fwd_a   = w_mem_a ? 2'd1 : (w_wb_a ? 2'd2 : 2'd0);
  assign fwd_b   = w_mem_b ? 2'd1 : (w_wb_b ? 2'd2 : 2'd0);

  assign w_lu = ex_regwrite && ex_memtoreg && (ex_rd != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halted     = 1'b0;
    w_stall_ev   = 1'b0;
    w_flush_ev   = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_flush_ev   = 1'b1;
        end else if (w_lu) begin
          // Jump/syscall in ID wait behind the bubble and re-present next cycle.
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
          w_stall_ev   = 1'b1;
        end else if (id_jmp) begin
          w_ifid_flush = 1'b1;
          w_flush_ev   = 1'b1;
        end else if (id_syscall) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
          w_state_nxt  = DRAIN;
          w_dcnt_nxt   = 2'd2;
        end
      end
      DRAIN: begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_flush = 1'b1;
        if (r_dcnt == 2'd0) w_state_nxt = HALT;
        else                w_dcnt_nxt  = r_dcnt - 2'd1;
      end
      HALT: begin
        w_halted     = 1'b1;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_flush = 1'b1;
        if (go) begin
          // Fetch resumes past the SYSCALL, which is dropped from IF/ID.
          w_pc_en      = 1'b1;
          w_ifid_en    = 1'b1;
          w_ifid_flush = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_dcnt_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_dcnt      <= 2'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      if (w_stall_ev && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_ev && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  // Reset overrides the control outputs so the pipe free-runs cleanly while held.
  assign pc_en      = rst | w_pc_en;
  assign ifid_en    = rst | w_ifid_en;
  assign ifid_flush = ~rst & w_ifid_flush;
  assign idex_flush = ~rst & w_idex_flush;
  assign halted     = ~rst & w_halted;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule
